lfsr_scheduler: RTL and testbench

Controller that owns the 8-bit LFSR random-number generator and shares it among up to N game-logic requesters. It loads seeds, steps the LFSR a fixed number of times per draw to decorrelate successive values, and returns each draw to one requester via round-robin arbitration. It also recovers the LFSR from the all-zero lock-up state. It sits between the LFSR instance and the spawn/placement logic in the processor.

---
 rtl/lfsr_scheduler.sv | 135 +++++++++++++
 tb/tb_lfsr_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_scheduler.sv
// Shares an external 8-bit LFSR among N_REQ requesters: seeding, multi-step draws,
// round-robin grant of each draw, and recovery from the all-zero lock-up state.
module lfsr_scheduler #(
    parameter int         N_REQ        = 4,
    parameter int         STEPS        = 8,
    parameter logic [7:0] DEFAULT_SEED = 8'hA5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [7:0]       rnd_data,
    input  logic             reseed_valid,
    input  logic [7:0]       reseed_value,
    output logic             reseed_ack,
    output logic             busy,
    output logic [7:0]       lfsr_seed,
    output logic             lfsr_select,
    output logic             lfsr_write,
    input  logic [7:0]       lfsr_out
);

    localparam int PW = $clog2(N_REQ);

    typedef enum logic [2:0] {INIT, IDLE, STEP, GRANT, SEED} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_q, win_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    rnd_q, rnd_d;
    logic          recov_q, recov_d;

    logic          win_found;
    logic [PW-1:0] win_idx;
    int            j;

    // Round-robin search: first asserted req at or after ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!win_found && req[PW'(j)]) begin
                win_found = 1'b1;
                win_idx   = PW'(j);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        rnd_d       = rnd_q;
        recov_d     = recov_q;
        gnt         = '0;
        reseed_ack  = 1'b0;
        lfsr_write  = 1'b0;
        lfsr_select = 1'b0;
        lfsr_seed   = DEFAULT_SEED;
        case (state_q)
            INIT: begin
                lfsr_write = 1'b1;
                state_d    = IDLE;
            end
            IDLE: begin
                if (reseed_valid) begin
                    recov_d = 1'b0;
                    state_d = SEED;
                end else if (win_found) begin
                    win_d   = win_idx;
                    cnt_d   = 4'(STEPS);
                    state_d = STEP;
                end
            end
            STEP: begin
                lfsr_write  = 1'b1;
                lfsr_select = 1'b1;
                cnt_d       = cnt_q - 4'd1;
                // The LFSR shifts mid-cycle, so lfsr_out already holds the last shift here.
                if (cnt_q == 4'd1) begin
                    rnd_d   = lfsr_out;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                gnt[win_q] = 1'b1;
                ptr_d      = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
                if (rnd_q == 8'h00) begin
                    recov_d = 1'b1;
                    state_d = SEED;
                end else begin
                    state_d = IDLE;
                end
            end
            SEED: begin
                lfsr_write = 1'b1;
                // Lock-up recovery reloads the default seed and is not acknowledged.
                if (!recov_q) begin
                    reseed_ack = 1'b1;
                    if (reseed_value != 8'h00) lfsr_seed = reseed_value;
                end
                recov_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= INIT;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            rnd_q   <= '0;
            recov_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            recov_q <= recov_d;
        end
    end

    assign rnd_data = rnd_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_scheduler.sv
// Directed bench for lfsr_scheduler with a falling-edge LFSR model and a grant scoreboard.
module tb_lfsr_scheduler;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] gnt;
    logic [7:0] rnd_data;
    logic       reseed_valid = 1'b0;
    logic [7:0] reseed_value = '0;
    logic       reseed_ack;
    logic       busy;
    logic [7:0] lfsr_seed;
    logic       lfsr_select;
    logic       lfsr_write;
    logic [7:0] lfsr_out;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] g;
        logic [7:0] r;
    } exp_t;
    exp_t sb[$];

    logic [7:0] env_lfsr = 8'h00;
    logic       force_zero = 1'b0;
    logic [7:0] exp_lfsr;

    always #5 clk = ~clk;

    lfsr_scheduler dut (
        .clk(clk), .clr(clr), .req(req), .gnt(gnt), .rnd_data(rnd_data),
        .reseed_valid(reseed_valid), .reseed_value(reseed_value), .reseed_ack(reseed_ack),
        .busy(busy), .lfsr_seed(lfsr_seed), .lfsr_select(lfsr_select),
        .lfsr_write(lfsr_write), .lfsr_out(lfsr_out)
    );

    function automatic logic [7:0] lfsr_nxt(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] lfsr_n(input logic [7:0] s, input int n);
        logic [7:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = lfsr_nxt(v);
        return v;
    endfunction

    // External LFSR: one shift or load per write cycle, on the falling edge.
    always @(negedge clk) begin
        if (force_zero)      env_lfsr <= 8'h00;
        else if (lfsr_write) env_lfsr <= lfsr_select ? lfsr_nxt(env_lfsr) : lfsr_seed;
    end
    assign lfsr_out = env_lfsr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every grant must match the oldest expected draw.
    always @(negedge clk) begin
        if (!clr && |gnt) begin
            if (sb.size() == 0) begin
                chk("sb_spurious_gnt", {28'h0, gnt}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_gnt", {28'h0, gnt}, {28'h0, e.g});
                chk("sb_rnd", {24'h0, rnd_data}, {24'h0, e.r});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // Reset and default seed load
        tick(); tick();
        chk("rst_busy", busy, 1);
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", reseed_ack, 0);
        chk("rst_rnd", rnd_data, 0);
        chk("init_ctl", {lfsr_write, lfsr_select, lfsr_seed}, {1'b1, 1'b0, 8'hA5});
        clr = 1'b0;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_write", lfsr_write, 0);
        chk("idle_lfsr", lfsr_out, 8'hA5);
        exp_lfsr = 8'hA5;

        // Single draw to requester 2
        req = 4'b0100;
        exp_lfsr = lfsr_n(exp_lfsr, 8);
        e.g = 4'b0100; e.r = exp_lfsr; sb.push_back(e);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("step_ctl", {lfsr_write, lfsr_select, gnt}, {1'b1, 1'b1, 4'b0000});
        end
        tick();
        chk("single_gnt", gnt, 4'b0100);
        chk("single_rnd", rnd_data, exp_lfsr);
        req = '0;
        tick();
        chk("single_idle", busy, 0);

        // Zero reseed substitutes the default seed
        reseed_valid = 1'b1; reseed_value = 8'h00;
        tick();
        chk("zseed_ctl", {reseed_ack, lfsr_write, lfsr_select, lfsr_seed}, {1'b1, 1'b1, 1'b0, 8'hA5});
        reseed_valid = 1'b0;
        tick();
        chk("zseed_lfsr", {reseed_ack, lfsr_out}, {1'b0, 8'hA5});
        exp_lfsr = 8'hA5;

        // Reseed and req[1] together: seed first, then the draw
        reseed_valid = 1'b1; reseed_value = 8'h3C; req = 4'b0010;
        exp_lfsr = lfsr_n(8'h3C, 8);
        e.g = 4'b0010; e.r = exp_lfsr; sb.push_back(e);
        tick();
        chk("coll_ack", {reseed_ack, lfsr_seed}, {1'b1, 8'h3C});
        reseed_valid = 1'b0;
        tick();
        chk("coll_idle", {busy, lfsr_out}, {1'b0, 8'h3C});
        for (int i = 0; i < 8; i++) tick();
        chk("coll_last_step", {lfsr_write, gnt}, {1'b1, 4'b0000});
        tick();
        chk("coll_gnt", gnt, 4'b0010);
        req = '0;
        tick();

        // Mid-draw reset abandons the draw
        req = 4'b1000;
        for (int i = 0; i < 4; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        req = '0;
        chk("mid_rst_state", {busy, gnt, rnd_data}, {1'b1, 4'b0000, 8'h00});
        chk("mid_rst_ctl", {lfsr_write, lfsr_select, lfsr_seed}, {1'b1, 1'b0, 8'hA5});
        tick();
        chk("mid_rst_lfsr", {busy, lfsr_out}, {1'b0, 8'hA5});
        exp_lfsr = 8'hA5;

        // ptr back at 0: 1010 must grant 1, then 1000 grants 3
        req = 4'b1010;
        exp_lfsr = lfsr_n(exp_lfsr, 8);
        e.g = 4'b0010; e.r = exp_lfsr; sb.push_back(e);
        for (int i = 0; i < 9; i++) tick();
        chk("ptr_rst_gnt", gnt, 4'b0010);
        req = 4'b1000;
        tick();
        exp_lfsr = lfsr_n(exp_lfsr, 8);
        e.g = 4'b1000; e.r = exp_lfsr; sb.push_back(e);
        for (int i = 0; i < 9; i++) tick();
        chk("post_rst_gnt", gnt, 4'b1000);
        req = '0;
        tick();

        // Fairness: all requesting, five back-to-back draws 10 cycles apart
        req = 4'b1111;
        for (int d = 0; d < 5; d++) begin
            exp_lfsr = lfsr_n(exp_lfsr, 8);
            e.g = 4'(1 << (d % 4)); e.r = exp_lfsr; sb.push_back(e);
        end
        for (int i = 0; i < 9; i++) tick();
        chk("fair_gnt0", gnt, 4'b0001);
        for (int d = 1; d < 5; d++) begin
            logic [3:0] eg;
            eg = 4'(1 << (d % 4));
            for (int i = 0; i < 10; i++) tick();
            chk("fair_gnt", gnt, {28'h0, eg});
        end
        req = '0;
        tick();

        // Lock-up: LFSR upset to zero yields rnd 0, then silent default reload
        force_zero = 1'b1;
        req = 4'b0001;
        reseed_value = 8'h77;
        e.g = 4'b0001; e.r = 8'h00; sb.push_back(e);
        tick();
        force_zero = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("lock_gnt", {gnt, rnd_data}, {4'b0001, 8'h00});
        req = '0;
        tick();
        chk("lock_seed", {busy, reseed_ack, lfsr_write, lfsr_select, lfsr_seed},
            {1'b1, 1'b0, 1'b1, 1'b0, 8'hA5});
        tick();
        chk("lock_recov", {busy, lfsr_out}, {1'b0, 8'hA5});

        tick();
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
